seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 175 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Also holds the parameterised combinational array
// multiplier used alongside it in the arithmetic datapath; multiplying the
// quotient by the divisor and adding the remainder rebuilds the dividend.

// Combinational array multiplier: each row adds one shifted, gated copy of
// 'a' into a running sum.
module seq_restoring_divider_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] acc [0:WIDTH];

  assign acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_row
      logic [2*WIDTH-1:0] pp;
      // Partial product for multiplier bit gi, aligned to its weight
      assign pp         = {{WIDTH{1'b0}}, (a & {WIDTH{b[gi]}})} << gi;
      assign acc[gi+1]  = acc[gi] + pp;
    end
  endgenerate

  assign p = acc[WIDTH];

endmodule

// Restoring divider. State flow: IDLE -> CALC (WIDTH iterations) -> DONE -> IDLE.
// A zero divisor skips CALC and reports div_by_zero with quotient all ones
// and remainder equal to the dividend.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder R
  logic [WIDTH-1:0] work_q, work_d;   // shifting dividend / growing quotient Q
  logic [WIDTH-1:0] dvs_q, dvs_d;     // latched divisor
  logic [CW-1:0]    cnt_q, cnt_d;     // iterations left after the current one
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // One iteration's datapath
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_iter;
  logic [WIDTH-1:0] work_iter;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor at
  // WIDTH+1 bits, keep the difference only when it is non-negative. R stays
  // below the divisor, so the shifted value always fits WIDTH+1 bits.
  always_comb begin
    r_shift   = {rem_q, work_q[WIDTH-1]};
    trial     = r_shift - {1'b0, dvs_q};
    fits      = ~trial[WIDTH];
    rem_iter  = fits ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    work_iter = {work_q[WIDTH-2:0], fits};
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvs_d   = divisor;
            rem_d   = '0;
            work_d  = dividend;
            cnt_d   = CW'(WIDTH - 1);
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end else begin
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        rem_d  = rem_iter;
        work_d = work_iter;
        if (cnt_q == '0) begin
          quo_d   = work_iter;
          rmd_d   = rem_iter;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=4), ending
// with an all-pairs sweep checked through the array multiplier.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic [3:0] mq;
  logic [3:0] md;
  logic [7:0] prod;

  int checks;
  int errors;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_restoring_divider_array_mult #(.WIDTH(4)) u_mult (
    .a (mq),
    .b (md),
    .p (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division once the block is idle and wait for done.
  // lat counts clock edges after the accepting edge until done is seen.
  task automatic run_div(input logic [3:0] n, input logic [3:0] d,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic z, output int lat, output bit to);
    int guard;
    to = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) to = 1'b1;
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) to = 1'b1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
    $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", n, d, q, r, z, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_results: q=%0d r=%0d dbz=%b expected 0 0 0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int busy_cnt;
    int done_cnt;
    int lat;
    int cyc;
    logic [3:0] q;
    logic [3:0] r;
    logic z;
    busy_cnt = 0; done_cnt = 0; lat = -1; cyc = 0;
    q = '0; r = '0; z = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (busy && cyc < 20) begin
      busy_cnt++;
      if (done) begin
        done_cnt++;
        lat = cyc;
        q = quotient;
        r = remainder;
        z = div_by_zero;
      end
      @(posedge clk); #1;
      cyc++;
    end
    $display("div 13/4 -> q=%0d r=%0d dbz=%0d lat=%0d busy_cycles=%0d", q, r, z, lat, busy_cnt);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    checks++;
    if (busy_cnt !== 5) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt);
    end
    checks++;
    if (q !== 4'd3 || r !== 4'd1 || z !== 1'b0) begin
      errors++; $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected 3 1 0", q, r, z);
    end
    checks++;
    if (quotient !== 4'd3 || remainder !== 4'd1) begin
      errors++; $display("FAIL basic_hold: q=%0d r=%0d expected 3 1", quotient, remainder);
    end
  endtask

  task automatic test_corners();
    logic [3:0] tn [4];
    logic [3:0] td [4];
    logic [3:0] tq [4];
    logic [3:0] tr [4];
    logic [3:0] q;
    logic [3:0] r;
    logic z;
    int lat;
    bit to;
    tn[0] = 4'd15; td[0] = 4'd1;  tq[0] = 4'd15; tr[0] = 4'd0;
    tn[1] = 4'd3;  td[1] = 4'd9;  tq[1] = 4'd0;  tr[1] = 4'd3;
    tn[2] = 4'd0;  td[2] = 4'd5;  tq[2] = 4'd0;  tr[2] = 4'd0;
    tn[3] = 4'd15; td[3] = 4'd15; tq[3] = 4'd1;  tr[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      run_div(tn[i], td[i], q, r, z, lat, to);
      checks++;
      if (to || q !== tq[i] || r !== tr[i] || z !== 1'b0 || lat !== 4) begin
        errors++;
        $display("FAIL corner_%0d_%0d: q=%0d r=%0d dbz=%b lat=%0d timeout=%0d expected q=%0d r=%0d dbz=0 lat=4",
                 tn[i], td[i], q, r, z, lat, to, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [3:0] q;
    logic [3:0] r;
    logic z;
    int lat;
    bit to;
    run_div(4'd7, 4'd0, q, r, z, lat, to);
    checks++;
    if (to || lat !== 0) begin
      errors++; $display("FAIL dbz_latency: got %0d (timeout=%0d) expected 0", lat, to);
    end
    checks++;
    if (q !== 4'd15 || r !== 4'd7 || z !== 1'b1) begin
      errors++; $display("FAIL dbz_result: q=%0d r=%0d dbz=%b expected 15 7 1", q, r, z);
    end
    run_div(4'd8, 4'd2, q, r, z, lat, to);
    checks++;
    if (to || q !== 4'd4 || r !== 4'd0 || z !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL dbz_followup: q=%0d r=%0d dbz=%b lat=%0d expected 4 0 0 lat=4", q, r, z, lat);
    end
  endtask

  task automatic test_busy_protect();
    int cyc;
    int extra_done;
    cyc = 0;
    extra_done = 0;
    while (busy && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    // mid-CALC request with different operands must be ignored
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    $display("div 13/4 with ignored 1/1 -> q=%0d r=%0d", quotient, remainder);
    checks++;
    if (!done || quotient !== 4'd3 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL busy_protect_result: done=%b q=%0d r=%0d expected 1 3 1", done, quotient, remainder);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++; $display("FAIL busy_protect_second_done: got %0d pulses expected 0", extra_done);
    end
  endtask

  task automatic test_reset_mid_calc();
    int cyc;
    int bad;
    logic [3:0] q;
    logic [3:0] r;
    logic z;
    int lat;
    bit to;
    cyc = 0;
    bad = 0;
    while (busy && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    $display("reset mid-calc -> busy=%b done=%b q=%0d r=%0d dbz=%b",
             busy, done, quotient, remainder, div_by_zero);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 4'd0 ||
        remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_calc_outputs: busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy || done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_mid_calc_idle: %0d active cycles expected 0", bad);
    end
    run_div(4'd9, 4'd2, q, r, z, lat, to);
    checks++;
    if (to || q !== 4'd4 || r !== 4'd1 || z !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL reset_mid_calc_recover: q=%0d r=%0d dbz=%b lat=%0d expected 4 1 0 lat=4", q, r, z, lat);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] nv;
    logic [3:0] dv;
    logic [3:0] q;
    logic [3:0] r;
    logic z;
    int lat;
    bit to;
    logic [7:0] rebuilt;
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        nv = 4'(n);
        dv = 4'(d);
        run_div(nv, dv, q, r, z, lat, to);
        checks++;
        if (to) begin
          errors++; $display("FAIL sweep_timeout_%0d_%0d: no done within bound", n, d);
        end
        if (d == 0) begin
          checks++;
          if (q !== 4'd15 || r !== nv || z !== 1'b1 || lat !== 0) begin
            errors++;
            $display("FAIL sweep_dbz_%0d: q=%0d r=%0d dbz=%b lat=%0d expected 15 %0d 1 lat=0", n, q, r, z, lat, n);
          end
        end else begin
          mq = q;
          md = dv;
          #1;
          rebuilt = prod + {4'd0, r};
          checks++;
          if (rebuilt !== {4'd0, nv} || r >= dv) begin
            errors++;
            $display("FAIL sweep_invariant_%0d_%0d: q*d+r=%0d r=%0d expected %0d and r<%0d",
                     n, d, rebuilt, r, n, d);
          end
          checks++;
          if (q !== 4'(n / d) || z !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL sweep_value_%0d_%0d: q=%0d dbz=%b lat=%0d expected %0d 0 lat=4",
                     n, d, q, z, lat, n / d);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mq = '0;
    md = '0;
    test_reset();
    test_basic();
    test_corners();
    test_div_by_zero();
    test_busy_protect();
    test_reset_mid_calc();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
